// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, parity modes and majority vote shared by the UART blocks (UART_RX_BREAK_EN adds ST_BREAK_WAIT)
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
`ifdef UART_RX_BREAK_EN
        , ST_BREAK_WAIT = 3'd5
`endif
    } state_e;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous input, flops preset to RST_VAL
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;
    // shift the raw input through two flops
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff_q <= {2{RST_VAL}};
        else        ff_q <= {ff_q[0], d_i};
    assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit majority vote and ready/valid holding register; UART_RX_BREAK_EN enables break detection
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RsRx,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
`ifdef UART_RX_BREAK_EN
    ,
    output logic                 o_break
`endif
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID_M = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] MID_P = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 fe_q, fe_d, pe_q, pe_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
    logic                 rx_s, vote, at_mid, at_end, done, load, brk_frame;
`ifdef UART_RX_BREAK_EN
    logic                 one_q, one_d, brk_q, brk_d;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(RsRx), .q_o(rx_s));

    assign vote   = maj3(smp_q[1], smp_q[0], rx_s);
    assign at_mid = cnt_q == MID_P;
    assign at_end = cnt_q == LAST;

    // frame FSM, bit sampling and holding-register next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = at_end ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q;
        smp_d     = smp_q;
        shift_d   = shift_q;
        fe_d      = fe_q;
        pe_d      = pe_q;
        done      = 1'b0;
        brk_frame = 1'b0;
`ifdef UART_RX_BREAK_EN
        one_d     = one_q;
        brk_d     = brk_q;
`endif
        if (cnt_q == MID_M) smp_d[1] = rx_s;
        if (cnt_q == MID)   smp_d[0] = rx_s;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                fe_d  = 1'b0;
                pe_d  = 1'b0;
`ifdef UART_RX_BREAK_EN
                one_d = 1'b0;
`endif
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (at_mid && vote) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (at_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_mid) shift_d = {vote, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_EN
                if (at_mid) one_d = one_q | vote;
`endif
                if (at_end) begin
                    bit_d = (bit_q == DLAST) ? '0 : bit_q + 4'd1;
                    if (bit_q == DLAST) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_mid) pe_d = vote != ((PARITY == PAR_ODD) ? ~^shift_q : ^shift_q);
`ifdef UART_RX_BREAK_EN
                if (at_mid) one_d = one_q | vote;
`endif
                if (at_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (at_mid) begin
                    fe_d = fe_q | ~vote;
                    if (bit_q == SLAST) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (at_end) bit_d = bit_q + 4'd1;
            end
`ifdef UART_RX_BREAK_EN
            ST_BREAK_WAIT: begin
                cnt_d = rx_s ? (at_end ? '0 : cnt_q + CW'(1)) : '0;
                if (rx_s && at_end) begin
                    state_d = ST_IDLE;
                    brk_d   = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef UART_RX_BREAK_EN
        brk_frame = done & ~one_q & fe_d;
        if (brk_frame) begin
            state_d = ST_BREAK_WAIT;
            brk_d   = 1'b1;
        end
`endif
        load    = done & ~brk_frame & (~valid_q | i_ready);
        valid_d = load | (valid_q & ~i_ready);
        ovr_d   = done & ~brk_frame & valid_q & ~i_ready;
        data_d  = load ? shift_q : data_q;
        ferr_d  = load ? fe_d : ferr_q;
        perr_d  = load ? pe_q : perr_q;
    end

    // receive-side state registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
        end

    // holding register and overrun pulse
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end

`ifdef UART_RX_BREAK_EN
    // break tracking: any received one, and the break level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            one_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            one_q <= one_d;
            brk_q <= brk_d;
        end
    assign o_break = brk_q;
`endif

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_frame_err  = ferr_q;
    assign o_parity_err = perr_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = state_q != ST_IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param with an 8N1 unit and an 8E2 unit
module tb_uart_rx_param;
    localparam int CPB = 16;
    localparam int LAT = CPB * 9 + CPB / 2 + 3 + 2;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       rx_n = 1'b1, rx_e = 1'b1, rdy_n = 1'b1, rdy_e = 1'b1;
    logic       v_n, v_e, fe_n, fe_e, pe_n, pe_e, ov_n, ov_e, bz_n, bz_e;
    logic [7:0] d_n, d_e;
`ifdef UART_RX_BREAK_EN
    logic       br_n, br_e;
`endif
    exp_t       q_n[$], q_e[$];
    int         vecs = 0, bad = 0, ovr_n = 0, ovr_e = 0, cyc = 0, t_start = 0;
    bit         lat_arm = 1'b0, rand_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .RsRx(rx_n), .i_ready(rdy_n), .o_valid(v_n), .o_data(d_n),
        .o_frame_err(fe_n), .o_parity_err(pe_n), .o_overrun(ov_n), .o_busy(bz_n)
`ifdef UART_RX_BREAK_EN
        , .o_break(br_n)
`endif
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_e (
        .clk(clk), .rst_n(rst_n), .RsRx(rx_e), .i_ready(rdy_e), .o_valid(v_e), .o_data(d_e),
        .o_frame_err(fe_e), .o_parity_err(pe_e), .o_overrun(ov_e), .o_busy(bz_e)
`ifdef UART_RX_BREAK_EN
        , .o_break(br_e)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // monitor for the 8N1 unit: latency, overrun pulses and accepted words
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (ov_n) ovr_n++;
        if (lat_arm && v_n) begin
            check("latency", cyc - t_start, LAT);
            lat_arm = 1'b0;
        end
        if (v_n && rdy_n) begin
            if (q_n.size() == 0) check("unexpected_n", {d_n, fe_n, pe_n}, 32'hFFFF);
            else begin
                e = q_n.pop_front();
                check("word_n", {d_n, fe_n, pe_n}, {e.d, e.fe, e.pe});
            end
        end
    end

    // monitor for the 8E2 unit
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (ov_e) ovr_e++;
        if (v_e && rdy_e) begin
            if (q_e.size() == 0) check("unexpected_e", {d_e, fe_e, pe_e}, 32'hFFFF);
            else begin
                e = q_e.pop_front();
                check("word_e", {d_e, fe_e, pe_e}, {e.d, e.fe, e.pe});
            end
        end
    end

    task automatic set_line(input int u, input logic b);
        if (u == 0) rx_n = b;
        else rx_e = b;
    endtask

    task automatic drive_bit(input int u, input logic b, input bit g);
        set_line(u, b);
        repeat (CPB / 2) @(negedge clk);
        if (g) set_line(u, ~b);
        @(negedge clk);
        set_line(u, b);
        repeat (CPB / 2 - 1) @(negedge clk);
    endtask

    // send one frame; the reference is built from what goes on the line
    task automatic send(input int u, input logic [7:0] d, input bit pflip, input logic [1:0] stop,
                        input int gbit, input bit drop);
        logic par;
        exp_t e;
        par  = (^d) ^ pflip;
        e.d  = d;
        e.pe = (u == 1) && (par != ^d);
        e.fe = (u == 0) ? ~stop[0] : ~&stop;
        if (!drop) begin
            if (u == 0) q_n.push_back(e);
            else q_e.push_back(e);
        end
        if (u == 0) t_start = cyc;
        drive_bit(u, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(u, d[i], i == gbit);
        if (u == 1) drive_bit(u, par, 1'b0);
        drive_bit(u, stop[0], 1'b0);
        if (u == 1) drive_bit(u, stop[1], 1'b0);
        set_line(u, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        int o0, u, gb;
        logic [7:0] d;
        logic [1:0] st;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_n", {v_n, d_n, fe_n, pe_n, ov_n, bz_n}, 0);
        check("reset_e", {v_e, d_e, fe_e, pe_e, ov_e, bz_e}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        lat_arm = 1'b1;
        send(0, 8'hA5, 1'b0, 2'b11, -1, 1'b0);
        check("latency_seen", {31'd0, lat_arm}, 0);

        send(1, 8'h03, 1'b1, 2'b11, -1, 1'b0);
        send(1, 8'h03, 1'b0, 2'b11, -1, 1'b0);

        send(0, 8'h55, 1'b0, 2'b10, -1, 1'b0);
        send(0, 8'h12, 1'b0, 2'b11, -1, 1'b0);
        send(1, 8'h7E, 1'b0, 2'b10, -1, 1'b0);
`ifndef UART_RX_BREAK_EN
        send(0, 8'h00, 1'b0, 2'b10, -1, 1'b0);
`endif

        rdy_n = 1'b0;
        o0 = ovr_n;
        send(0, 8'h11, 1'b0, 2'b11, -1, 1'b0);
        send(0, 8'h22, 1'b0, 2'b11, -1, 1'b1);
        #1;
        check("hold_data", {24'd0, d_n}, 8'h11);
        check("hold_valid", {31'd0, v_n}, 1);
        check("overrun_pulses", ovr_n - o0, 1);
        @(negedge clk);
        rdy_n = 1'b1;
        @(negedge clk);
        #2;
        check("valid_drop", {31'd0, v_n}, 0);

        rx_n = 1'b0;
        repeat (3) @(negedge clk);
        rx_n = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_idle", {31'd0, bz_n}, 0);

        send(0, 8'h5A, 1'b0, 2'b11, 3, 1'b0);
        send(1, 8'hC3, 1'b0, 2'b11, 0, 1'b0);

        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, i[0], 1'b0);
        rx_n = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_midframe", {31'd0, bz_n}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {v_n, d_n, fe_n, pe_n, ov_n, bz_n}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(0, 8'h3C, 1'b0, 2'b11, -1, 1'b0);

        rand_rdy = 1'b1;
        fork
            while (rand_rdy) begin
                @(negedge clk);
                rdy_n = 1'($urandom_range(0, 1));
                rdy_e = 1'($urandom_range(0, 1));
            end
        join_none
        for (int k = 0; k < 12; k++) begin
            u  = int'($urandom_range(0, 1));
            d  = 8'($urandom);
            st = (d != 0 && $urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            if (u == 0) st[1] = 1'b1;
            gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            send(u, d, $urandom_range(0, 3) == 0, st, gb, 1'b0);
        end
        rand_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rdy_n = 1'b1;
        rdy_e = 1'b1;

        for (int i = 0; i < 400 && (q_n.size() + q_e.size()) != 0; i++) @(negedge clk);
        check("drain", q_n.size() + q_e.size(), 0);
        check("overrun_total", ovr_n + ovr_e, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end
endmodule
